// File: rtl/seq_detect_pkg.sv
// rtl/seq_detect_pkg.sv - shared FSM state type and constants for seq_detect_prog
package seq_detect_pkg;

  localparam int MIN_LEN = 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_HUNT
  } state_t;

endpackage

// File: rtl/seq_detect_sat_cnt.sv
// rtl/seq_detect_sat_cnt.sv - saturating up-counter with synchronous clear
module seq_detect_sat_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seq_detect_prog.sv
// rtl/seq_detect_prog.sv - programmable serial pattern detector (match counter built under SEQ_DETECT_CNT_EN)
module seq_detect_prog
  import seq_detect_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8,
  localparam int LEN_W  = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               in_valid,
  input  logic               in_bit,
  output logic               seq_seen,
  output logic [CNT_W-1:0]   match_count,
  output logic               armed
);

  state_t             state;
  logic [MAX_LEN-1:0] hist;
  logic [MAX_LEN-1:0] pattern;
  logic [LEN_W-1:0]   len;
  logic [LEN_W-1:0]   fill;
  logic               overlap;

  logic [MAX_LEN-1:0] hist_next;
  logic [MAX_LEN-1:0] len_mask;
  logic [LEN_W-1:0]   fill_next;
  logic [LEN_W-1:0]   cfg_len_c;
  logic               cfg_legal;
  logic               accept;
  logic               hit;

  always_comb begin
    cfg_len_c = (cfg_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cfg_len;
    cfg_legal = (cfg_len >= LEN_W'(MIN_LEN));
    accept    = in_valid && !cfg_we && (state != S_IDLE);
    hist_next = {hist[MAX_LEN-2:0], in_bit};
    fill_next = (fill >= len) ? len : fill + LEN_W'(1);
    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (LEN_W'(i) < len);
    end
    // Only the low len bits of history and pattern take part in the compare.
    hit = accept && (fill_next == len) && (((hist_next ^ pattern) & len_mask) == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      hist     <= '0;
      fill     <= '0;
      pattern  <= '0;
      len      <= '0;
      overlap  <= 1'b0;
      seq_seen <= 1'b0;
      armed    <= 1'b0;
    end else if (cfg_we) begin
      state    <= cfg_legal ? S_FILL : S_IDLE;
      armed    <= cfg_legal;
      hist     <= '0;
      fill     <= '0;
      pattern  <= cfg_pattern;
      len      <= cfg_len_c;
      overlap  <= cfg_overlap;
      seq_seen <= 1'b0;
    end else if (accept) begin
      hist     <= hist_next;
      seq_seen <= hit;
      if (hit && !overlap) begin
        fill  <= '0;
        state <= S_FILL;
      end else begin
        fill  <= fill_next;
        state <= (fill_next == len) ? S_HUNT : S_FILL;
      end
    end else begin
      seq_seen <= 1'b0;
    end
  end

`ifdef SEQ_DETECT_CNT_EN
  seq_detect_sat_cnt #(
    .CNT_W(CNT_W)
  ) u_sat_cnt (
    .clk  (clk),
    .reset(reset),
    .clr  (cfg_we),
    .inc  (hit),
    .count(match_count)
  );
`else
  assign match_count = '0;
`endif

endmodule

// File: doc/seq_detect_prog.md
SEQ_DETECT_PROG -- requirements
Module: seq_detect_prog

Interface
REQ-001 SHALL have parameter MAX_LEN, default 8: maximum pattern length in bits, legal range 2..16.
REQ-002 SHALL have parameter CNT_W, default 8: match counter width.
REQ-003 SHALL have localparam LEN_W = $clog2(MAX_LEN+1).
REQ-004 clk  input  1  clock; all state updates on posedge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 cfg_we  input  1  load pattern, length and mode this cycle.
REQ-007 cfg_pattern  input  MAX_LEN  pattern; bit cfg_len-1 is the first bit received, bit 0 the last.
REQ-008 cfg_len  input  LEN_W  pattern length in bits.
REQ-009 cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
REQ-010 in_valid  input  1  in_bit is accepted this cycle.
REQ-011 in_bit  input  1  serial data bit.
REQ-012 seq_seen  output  1  registered one-cycle pulse per detected match.
REQ-013 match_count  output  CNT_W  saturating count of matches since last reset or configuration load.
REQ-014 armed  output  1  high when a legal configuration is loaded (FSM not in S_IDLE).

Function
REQ-015 FSM SHALL have states S_IDLE (unconfigured), S_FILL (history holds fewer than len valid bits) and S_HUNT (history holds at least len valid bits).
REQ-016 Accepted bit (in_valid=1 and cfg_we=0, state not S_IDLE) SHALL shift into history register hist[MAX_LEN-1:0] at LSB and increment fill counter; fill SHALL saturate at len.
REQ-017 In S_IDLE, in_valid SHALL be ignored: no shift, no match.
REQ-018 Match SHALL be flagged when an accepted bit makes fill reach or stay at len and hist[len-1:0] after the shift equals pattern[len-1:0].
REQ-019 seq_seen SHALL be high exactly in the cycle after the accepted bit that completes a match (latency 1), otherwise low; cycles with in_valid=0 SHALL not change seq_seen from low.
REQ-020 Overlap mode: fill SHALL be unchanged after a match, so a pattern suffix can start the next match.
REQ-021 Non-overlap mode: fill SHALL clear to 0 on a match and the FSM SHALL go to S_FILL.
REQ-022 Transitions: S_FILL->S_HUNT when fill reaches len; S_HUNT->S_FILL on non-overlap match; any state->S_FILL on legal cfg_we; any state->S_IDLE on illegal cfg_we.
REQ-023 cfg_we SHALL capture pattern, len and overlap, clear hist, fill and match_count, and take priority over in_valid in the same cycle; that bit SHALL be discarded.
REQ-024 cfg_len of 0 or 1 SHALL be illegal (state S_IDLE, armed=0); cfg_len > MAX_LEN SHALL be clamped to MAX_LEN.
REQ-025 match_count SHALL increment by 1 per match and hold at 2^CNT_W-1.
REQ-026 Pattern bits above len-1 SHALL be ignored in comparison.

Reset
REQ-027 Reset SHALL force S_IDLE, hist=0, fill=0, pattern=0, len=0, overlap=0, seq_seen=0, match_count=0, armed=0.
REQ-028 Reset SHALL take priority over cfg_we and in_valid, including mid-match.

Configuration
REQ-029 Macro SEQ_DETECT_CNT_EN defined: match_count SHALL behave per REQ-025.
REQ-030 Macro SEQ_DETECT_CNT_EN undefined: the counter SHALL not be built and match_count SHALL be constant 0; all other behaviour unchanged.

Structure
REQ-031 Package seq_detect_pkg SHALL hold the FSM state typedef (S_IDLE, S_FILL, S_HUNT) and the MIN_LEN=2 constant.
REQ-032 The saturating counter SHALL be sub-module seq_detect_sat_cnt (parameter CNT_W; inputs clk, reset, clr, inc; output count), instantiated only under SEQ_DETECT_CNT_EN.

Verification
REQ-033 Load 1011, len 4, overlap=1; stream 1,0,1,1,0,1,1 -> seq_seen pulses after bits 4 and 7; match_count=2.
REQ-034 Same config, overlap=0; stream 1,0,1,1,0,1,1 -> single pulse after bit 4; match_count=1.
REQ-035 Load 111, len 3, overlap=1; six consecutive 1s with in_valid gaps between bits -> 4 pulses, each one cycle, none in gap cycles.
REQ-036 cfg_len=0 then stream 1011 -> armed=0, no pulse; cfg_len=12 with MAX_LEN=8 -> len clamped to 8, armed=1.
REQ-037 CNT_W=2, pattern 11 len 2 overlap=1, stream of six 1s -> match_count saturates at 3.
REQ-038 Assert reset and separately cfg_we in the cycle that would complete 1011 -> no pulse; reset gives S_IDLE, cfg_we gives S_FILL with fill=0.
